// File: rtl/zjh_vote_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : zjh_vote_ctrl_if
// Description : Session bundle between the vote-session controller and its
//               driver: START pulse and raw judge keys in, latched votes and
//               session status out.
// Revision    : 1.0  initial release
// ============================================================================
interface zjh_vote_ctrl_if;
   logic       start;   // open a new voting session (single-cycle pulse)
   logic       key_a;   // raw judge keys, asynchronous and bouncy
   logic       key_b;
   logic       key_c;
   logic       va;      // latched votes, wired straight to the voter A/B/C
   logic       vb;
   logic       vc;
   logic [1:0] votes;   // number of votes latched so far
   logic       busy;    // voting window open
   logic       valid;   // va/vb/vc final
   logic       done;    // one-cycle pulse when the session closes

   // Driver side: the test environment or the console logic
   modport master (
      output start, key_a, key_b, key_c,
      input  va, vb, vc, votes, busy, valid, done
   );

   // Controller side
   modport slave (
      input  start, key_a, key_b, key_c,
      output va, vb, vc, votes, busy, valid, done
   );
endinterface : zjh_vote_ctrl_if
`default_nettype wire

// File: rtl/zjh_vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : zjh_vote_ctrl
// Description : Vote-session front end for the 3-input majority voter.
//               Synchronises and debounces three judge keys, opens a timed
//               voting window on START and latches one sticky vote per judge.
//               When the window closes (timeout or all three voted) the
//               votes are frozen and flagged valid.
// Revision    : 1.0  initial release
// ============================================================================
module zjh_vote_ctrl #(
   parameter int DB_CYCLES  = 4,   // cycles a synced level must persist (>=2)
   parameter int WIN_CYCLES = 16   // voting window length in cycles (>=2)
) (
   input  logic            clk,
   input  logic            rst_n,
   zjh_vote_ctrl_if.slave  bus
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int c_DBW = $clog2(DB_CYCLES);
   localparam int c_WW  = $clog2(WIN_CYCLES);

   // A debounce counter reaching this value means the mismatch has now been
   // seen for DB_CYCLES consecutive cycles, so the level is accepted.
   localparam logic [c_DBW-1:0] c_DB_LAST  = c_DBW'(DB_CYCLES - 1);
   localparam logic [c_WW-1:0]  c_WIN_LAST = c_WW'(WIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   // -------------------------------------------------------------------------
   // Declarations
   // -------------------------------------------------------------------------
   logic [2:0]      w_key_raw;     // {c, b, a}
   logic [2:0]      w_rise;        // debounced 0->1 edge per key

   state_t          r_state;
   state_t          w_state_nxt;
   logic [2:0]      r_flags;       // sticky votes {vc, vb, va}
   logic [2:0]      w_flags_nxt;
   logic [c_WW-1:0] r_win_cnt;
   logic [c_WW-1:0] w_win_cnt_nxt;
   logic [1:0]      r_votes;
   logic [1:0]      w_votes_nxt;
   logic            r_done;
   logic            w_done_nxt;

   assign w_key_raw = {bus.key_c, bus.key_b, bus.key_a};

   // -------------------------------------------------------------------------
   // Per-key input path: 2-FF synchroniser, debouncer, edge detector.
   // The edge detector compares the debounced level against its own delayed
   // copy, so a key that was already debounced-high when the window opens
   // produces no edge until it is released and pressed again.
   // -------------------------------------------------------------------------
   generate
      for (genvar g = 0; g < 3; g++) begin : g_key
         logic             r_sync1;
         logic             r_sync2;
         logic             r_deb;
         logic             r_deb_q;
         logic [c_DBW-1:0] r_cnt;

         // Synchronise, debounce and delay the debounced level for edge detect
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sync1 <= 1'b0;
               r_sync2 <= 1'b0;
               r_deb   <= 1'b0;
               r_deb_q <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_sync1 <= w_key_raw[g];
               r_sync2 <= r_sync1;
               r_deb_q <= r_deb;
               if (r_sync2 == r_deb) begin
                  // any cycle of agreement restarts the qualification
                  r_cnt <= '0;
               end else if (r_cnt == c_DB_LAST) begin
                  r_deb <= r_sync2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end

         assign w_rise[g] = r_deb & ~r_deb_q;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Session FSM
   // -------------------------------------------------------------------------

   // Next-state, window counter and sticky-vote update
   always_comb begin
      w_state_nxt   = r_state;
      w_flags_nxt   = r_flags;
      w_win_cnt_nxt = r_win_cnt;

      case (r_state)
         ST_IDLE, ST_HOLD: begin
            // An edge arriving together with START is not counted: the
            // flags are only opened for update once the state is COLLECT.
            if (bus.start) begin
               w_state_nxt   = ST_COLLECT;
               w_flags_nxt   = 3'b000;
               w_win_cnt_nxt = '0;
            end
         end

         ST_COLLECT: begin
            // Edges in the last window cycle still land in the flags.
            w_flags_nxt = r_flags | w_rise;
            if ((r_win_cnt == c_WIN_LAST) || (&r_flags)) begin
               w_state_nxt = ST_HOLD;
            end else begin
               w_win_cnt_nxt = r_win_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_votes_nxt = {1'b0, w_flags_nxt[0]}
                  + {1'b0, w_flags_nxt[1]}
                  + {1'b0, w_flags_nxt[2]};
      w_done_nxt  = (w_state_nxt == ST_HOLD) && (r_state != ST_HOLD);
   end

   // State, flags, vote count and DONE pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_flags   <= 3'b000;
         r_win_cnt <= '0;
         r_votes   <= 2'd0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_flags   <= w_flags_nxt;
         r_win_cnt <= w_win_cnt_nxt;
         r_votes   <= w_votes_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs (all derived directly from registers)
   // -------------------------------------------------------------------------
   assign bus.va    = r_flags[0];
   assign bus.vb    = r_flags[1];
   assign bus.vc    = r_flags[2];
   assign bus.votes = r_votes;
   assign bus.busy  = (r_state == ST_COLLECT);
   assign bus.valid = (r_state == ST_HOLD);
   assign bus.done  = r_done;

endmodule : zjh_vote_ctrl
`default_nettype wire

// File: tb/tb_zjh_vote_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_zjh_vote_ctrl
// Description : Directed self-checking bench for zjh_vote_ctrl
//               (DB_CYCLES=4, WIN_CYCLES=16). Inputs change and outputs are
//               sampled on the falling clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_zjh_vote_ctrl;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   n;

   zjh_vote_ctrl_if bus ();

   zjh_vote_ctrl #(
      .DB_CYCLES  (4),
      .WIN_CYCLES (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence below ever stalls
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   // Count falling edges on which busy is seen high, stopping at the first
   // low sample; bounded so a stuck window shows up as a wrong count.
   task automatic count_busy(output int cnt);
      cnt = 0;
      while (bus.busy && cnt < 40) begin
         cnt++;
         step(1);
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.key_a = 1'b0;
      bus.key_b = 1'b0;
      bus.key_c = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(1);

      // ---- reset state ----
      chk("rst_busy",  bus.busy,  0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_done",  bus.done,  0);
      chk("rst_votes", bus.votes, 0);
      chk("rst_flags", {bus.vc, bus.vb, bus.va}, 3'b000);
      step(2);
      chk("idle_stays", bus.busy, 0);

      // ---- full window: A and C vote, B idle ----
      pulse_start();                       // now at window cycle 0
      chk("win_busy0", bus.busy, 1);
      bus.key_a = 1'b1;
      bus.key_c = 1'b1;
      count_busy(n);
      chk("win_len",   n,         16);
      chk("win_valid", bus.valid, 1);
      chk("win_done",  bus.done,  1);
      chk("win_flags", {bus.vc, bus.vb, bus.va}, 3'b101);
      chk("win_votes", bus.votes, 2);
      step(1);
      chk("win_done_1cyc", bus.done,  0);
      chk("win_valid_hold", bus.valid, 1);
      bus.key_a = 1'b0;
      bus.key_c = 1'b0;
      step(10);
      chk("hold_frozen", {bus.vc, bus.vb, bus.va}, 3'b101);

      // ---- restart from HOLD, START during COLLECT ignored ----
      pulse_start();                       // window cycle 0
      chk("rs_busy",  bus.busy,  1);
      chk("rs_valid", bus.valid, 0);
      chk("rs_flags", {bus.vc, bus.vb, bus.va}, 3'b000);
      chk("rs_votes", bus.votes, 0);
      step(3);
      pulse_start();                       // window cycle 4
      count_busy(n);
      chk("rs_len_rem", n, 12);
      chk("rs_valid_end", bus.valid, 1);
      chk("rs_votes_end", bus.votes, 0);

      // ---- early close: A, B, C pressed on cycles 0, 1, 2 ----
      pulse_start();
      bus.key_a = 1'b1;
      step(1);
      bus.key_b = 1'b1;
      step(1);
      bus.key_c = 1'b1;
      step(4);                             // cycle 6
      chk("ec_a_lat_early", bus.va, 0);
      step(1);                             // cycle 7
      chk("ec_a_lat", {bus.vc, bus.vb, bus.va}, 3'b001);
      step(1);                             // cycle 8
      chk("ec_ab", {bus.vc, bus.vb, bus.va}, 3'b011);
      chk("ec_votes2", bus.votes, 2);
      step(1);                             // cycle 9
      chk("ec_abc", {bus.vc, bus.vb, bus.va}, 3'b111);
      chk("ec_votes3", bus.votes, 3);
      chk("ec_busy9", bus.busy, 1);
      step(1);
      chk("ec_hold_valid", bus.valid, 1);
      chk("ec_hold_busy",  bus.busy,  0);
      chk("ec_done",       bus.done,  1);
      step(1);
      chk("ec_done_once", bus.done, 0);
      bus.key_a = 1'b0;
      bus.key_b = 1'b0;
      bus.key_c = 1'b0;
      step(10);

      // ---- pre-held key B ----
      bus.key_b = 1'b1;
      step(10);
      pulse_start();
      count_busy(n);
      chk("ph_len",   n, 16);
      chk("ph_vb",    bus.vb, 0);
      chk("ph_votes", bus.votes, 0);
      // release on cycle 0, re-press on cycle 8: vote lands on cycle 15
      pulse_start();
      bus.key_b = 1'b0;
      step(8);
      bus.key_b = 1'b1;
      count_busy(n);
      chk("ph2_len_rem", n, 8);
      chk("ph2_vb",    bus.vb, 1);
      chk("ph2_votes", bus.votes, 1);
      bus.key_b = 1'b0;
      step(10);

      // ---- bounce on A: toggles t0..t9, stable 1 from t10; START at t3 ----
      for (int i = 0; i < 17; i++) begin
         if (i < 10)
            bus.key_a = (i % 2 == 0);
         else
            bus.key_a = 1'b1;
         bus.start = (i == 3);
         step(1);
         if (i < 16)
            chk("bnc_novote", bus.va, 0);
         else
            chk("bnc_vote_lat", bus.va, 1);
      end
      count_busy(n);
      chk("bnc_len_rem", n, 3);
      chk("bnc_votes",   bus.votes, 1);
      bus.key_a = 1'b0;
      step(10);

      // ---- asynchronous reset mid-COLLECT with VA=1 ----
      pulse_start();
      bus.key_a = 1'b1;
      step(8);
      chk("ar_pre_va",   bus.va,   1);
      chk("ar_pre_busy", bus.busy, 1);
      #2;
      rst_n     = 1'b0;
      bus.key_a = 1'b0;
      #1;
      chk("ar_va",    bus.va,    0);
      chk("ar_busy",  bus.busy,  0);
      chk("ar_votes", bus.votes, 0);
      chk("ar_valid", bus.valid, 0);
      step(2);
      rst_n = 1'b1;
      step(3);
      chk("ar_idle_busy",  bus.busy,  0);
      chk("ar_idle_valid", bus.valid, 0);
      chk("ar_idle_done",  bus.done,  0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_zjh_vote_ctrl
`default_nettype wire
